// File: rtl/jpeg_stream_pkg.sv
// Shared definitions for the JPEG entropy-coded-segment byte stream.
//   state_e        : byte stuffer FSM states
//   MARKER_PREFIX  : 0xFF, the byte that needs stuffing and that opens a marker
//   EOI_CODE       : second byte of the end-of-image marker
//   STUFF_BYTE     : byte inserted after every 0xFF data byte
//   word_bytes()   : number of bytes to emit from one 32-bit input word
package jpeg_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BYTES,
        ST_STUFF,
        ST_EOI_FF,
        ST_EOI_D9
    } state_e;

    localparam logic [7:0] MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] EOI_CODE      = 8'hD9;
    localparam logic [7:0] STUFF_BYTE    = 8'h00;

    // A full word carries 4 bytes; a final word carries ceil(last_bits/8),
    // with last_bits == 0 meaning all 32 bits are valid.
    function automatic logic [2:0] word_bytes(input logic last, input logic [4:0] last_bits);
        logic [5:0] sum;
        sum = {1'b0, last_bits} + 6'd7;
        if (!last || last_bits == 5'd0) begin
            return 3'd4;
        end
        return sum[5:3];
    endfunction

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Converts 32-bit compressed words into an MSB-first JPEG byte stream:
// 0x00 stuffed after every 0xFF data byte, the final partial byte padded
// with 1s, and an optional 0xFFD9 EOI marker appended.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_data/in_valid/in_ready     word input (bit 31 first), accepted only in IDLE
//   in_last, in_last_bits         final word marker and its valid bit count (0 = 32)
//   out_data/out_valid/out_ready  registered byte output with backpressure
//   out_last                      final byte of the image
//   byte_count, stuff_count       saturating per-frame counters
//   busy, done                    FSM not idle; one-cycle pulse after the final byte
module jpeg_byte_stuffer
    import jpeg_stream_pkg::*;
#(
    parameter bit EMIT_EOI = 1'b1,
    parameter int CNT_W    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [4:0]       in_last_bits,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] byte_count,
    output logic [CNT_W-1:0] stuff_count,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [31:0]      hold_q, hold_d;
    logic [1:0]       k_q, k_d;
    logic [2:0]       n_q, n_d;
    logic             last_q, last_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic [CNT_W-1:0] stuff_count_q, stuff_count_d;
    logic             done_q, done_d;
    // Set when a frame completes; the next accepted word starts a new frame
    // and clears the counters.
    logic             frame_done_q, frame_done_d;

    logic             hs;
    logic             advance;
    logic [7:0]       cur_byte;
    logic [7:0]       nxt_byte;
    logic             cur_final;
    logic             nxt_final;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign hs        = out_valid_q && out_ready;
    assign cur_byte  = byte_of(hold_q, k_q);
    assign cur_final = ({1'b0, k_q} == (n_q - 3'd1));

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        k_d           = k_q;
        n_d           = n_q;
        last_d        = last_q;
        byte_count_d  = byte_count_q;
        stuff_count_d = stuff_count_q;
        done_d        = 1'b0;
        frame_done_d  = frame_done_q;
        advance       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Pad the unused tail of a final word with 1s at latch time.
                    hold_d = in_data |
                             ((in_last && in_last_bits != 5'd0) ? (32'hFFFF_FFFF >> in_last_bits)
                                                                : 32'h0);
                    k_d     = 2'd0;
                    n_d     = word_bytes(in_last, in_last_bits);
                    last_d  = in_last;
                    state_d = ST_BYTES;
                    if (frame_done_q) begin
                        byte_count_d  = '0;
                        stuff_count_d = '0;
                        frame_done_d  = 1'b0;
                    end
                end
            end
            ST_BYTES: begin
                if (hs) begin
                    byte_count_d = sat_inc(byte_count_q);
                    if (cur_byte == MARKER_PREFIX) state_d = ST_STUFF;
                    else                           advance = 1'b1;
                end
            end
            ST_STUFF: begin
                if (hs) begin
                    byte_count_d  = sat_inc(byte_count_q);
                    stuff_count_d = sat_inc(stuff_count_q);
                    advance       = 1'b1;
                end
            end
            ST_EOI_FF: begin
                if (hs) begin
                    byte_count_d = sat_inc(byte_count_q);
                    state_d      = ST_EOI_D9;
                end
            end
            ST_EOI_D9: begin
                if (hs) begin
                    byte_count_d = sat_inc(byte_count_q);
                    state_d      = ST_IDLE;
                    done_d       = 1'b1;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared next-byte / word-complete decision after a data or stuff byte.
        if (advance) begin
            if (!cur_final) begin
                k_d     = k_q + 2'd1;
                state_d = ST_BYTES;
            end else if (last_q && EMIT_EOI) begin
                state_d = ST_EOI_FF;
            end else begin
                state_d = ST_IDLE;
                if (last_q) begin
                    done_d       = 1'b1;
                    frame_done_d = 1'b1;
                end
            end
        end
    end

    // Outputs are derived from the next state so they land in flops together
    // with it; while stalled nothing changes, so they hold steady.
    assign nxt_byte  = byte_of(hold_d, k_d);
    assign nxt_final = last_d && ({1'b0, k_d} == (n_d - 3'd1));

    always_comb begin
        out_valid_d = 1'b1;
        out_data_d  = out_data_q;
        out_last_d  = 1'b0;
        case (state_d)
            ST_BYTES: begin
                out_data_d = nxt_byte;
                // A trailing 0xFF hands the last flag to its stuff byte.
                out_last_d = !EMIT_EOI && nxt_final && (nxt_byte != MARKER_PREFIX);
            end
            ST_STUFF: begin
                out_data_d = STUFF_BYTE;
                out_last_d = !EMIT_EOI && nxt_final;
            end
            ST_EOI_FF: out_data_d = MARKER_PREFIX;
            ST_EOI_D9: begin
                out_data_d = EOI_CODE;
                out_last_d = 1'b1;
            end
            default:   out_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hold_q        <= 32'h0;
            k_q           <= 2'd0;
            n_q           <= 3'd4;
            last_q        <= 1'b0;
            out_data_q    <= 8'h00;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            byte_count_q  <= '0;
            stuff_count_q <= '0;
            done_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            k_q           <= k_d;
            n_q           <= n_d;
            last_q        <= last_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            byte_count_q  <= byte_count_d;
            stuff_count_q <= stuff_count_d;
            done_q        <= done_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign byte_count  = byte_count_q;
    assign stuff_count = stuff_count_q;
    assign done        = done_q;

endmodule

// File: doc/jpeg_byte_stuffer.md
Name: jpeg_byte_stuffer

Overview:
Downstream stage of the JPEG encoder output FIFO. It consumes 32-bit compressed-stream words and emits a byte stream in JPEG entropy-coded-segment form:
- MSB-first byte order.
- 0x00 stuffed after every 0xFF data byte.
- Final partial byte padded with 1s.
- Optional EOI marker (0xFFD9) appended.

The output feeds the DMA/host byte sink, so software no longer has to post-process words or the end-of-stream bit count.

Parameters:
EMIT_EOI, 1, append 0xFF 0xD9 after the final data byte when 1.
CNT_W, 24, width of the emitted-byte and stuffed-byte counters.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_data  input  32  compressed word; bit 31 is the first bit in the stream
in_valid  input  1  in_data valid
in_ready  output  1  word accepted when in_valid && in_ready
in_last  input  1  word is the final word of the image
in_last_bits  input  5  valid bits in the final word, MSB-aligned; 0 means 32; ignored unless in_last
out_data  output  8  stream byte
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts the byte when out_valid && out_ready
out_last  output  1  final byte of the image
byte_count  output  CNT_W  bytes emitted since the last frame start (includes stuffing and EOI)
stuff_count  output  CNT_W  0x00 stuff bytes emitted since the last frame start
busy  output  1  state != IDLE
done  output  1  one-cycle pulse after the out_last handshake

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous, active-high.
  - Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, byte_count=0, stuff_count=0, busy=0, done=0, state=IDLE.
  - Reset mid-word discards the held word and any pending stuff or EOI bytes.
- States: IDLE, BYTES, STUFF, EOI_FF, EOI_D9.
- IDLE:
  - in_ready=1, out_valid=0.
  - On accept: latch in_data into a holding register, set byte index k=0, latch in_last.
  - Latch n = number of bytes in the word: n=4 if !in_last or in_last_bits==0, else ceil(in_last_bits/8) (1..4).
  - Bits below in_last_bits in the final word are forced to 1 in the holding register at latch time.
  - Next state is BYTES.
  - If byte_count and stuff_count are nonzero from a completed frame, they clear on the first accept after done.
- BYTES:
  - out_valid=1, out_data = byte k of the holding register (k=0 is bits 31:24).
  - On handshake, byte_count increments.
  - If the byte is 0xFF, go to STUFF.
  - Otherwise, if k<n-1, increment k.
  - Otherwise, the word is complete:
    - last word and EMIT_EOI → EOI_FF
    - last word and !EMIT_EOI → IDLE, with done pulsed
    - not last → IDLE
- STUFF:
  - out_valid=1, out_data=0x00.
  - On handshake, byte_count and stuff_count increment.
  - Then apply the same k/word-complete decision as BYTES.
- EOI_FF:
  - Emits 0xFF; this byte is never stuffed.
  - Goes to EOI_D9 on handshake.
- EOI_D9:
  - Emits 0xD9 with out_last=1.
  - Goes to IDLE on handshake, with done pulsed.
- out_last (EMIT_EOI=0): asserted on the final data byte, or on its trailing stuff byte if that byte is 0xFF.
- Output handshake:
  - out_valid, out_data and out_last are registered.
  - They stay stable while out_valid && !out_ready.
  - out_valid never drops without a handshake.
- in_ready is low in all states except IDLE.
- Throughput: one byte per cycle while out_ready=1, plus one idle cycle per word (the IDLE accept cycle).
- Latency: the first byte is presented the cycle after word accept.
- Counters saturate at all-ones; they do not wrap.
- A padded final byte equal to 0xFF (e.g. in_last_bits=8 with data 0xFF) is still stuffed.
- in_valid while busy is ignored (held by upstream).

Decomposition:
- Package jpeg_stream_pkg holds:
  - the state enum type;
  - constants MARKER_PREFIX=8'hFF, EOI_CODE=8'hD9, STUFF_BYTE=8'h00;
  - a function computing the byte count n from (last, last_bits).
- No sub-module; a single flat module.

Test Plan:
- Word 0x12345678, not last, out_ready=1 → bytes 12 34 56 78, in_ready low for 4 cycles, byte_count=4, stuff_count=0.
- Word 0x12FF34FF, not last → 12 FF 00 34 FF 00, stuff_count=2, byte_count=6.
- Final word 0xA0000000, in_last_bits=3, EMIT_EOI=1 → BF FF D9, out_last only on D9, done pulses the cycle after, byte_count=3.
- Final word 0xFFFF0000, in_last_bits=8, EMIT_EOI=0 → FF 00 with out_last on 00, stuff_count=1.
- Random out_ready backpressure over 16 random words → out_data/out_valid stable while stalled; the byte sequence matches the reference model exactly.
- rst asserted mid-STUFF → next cycle out_valid=0, in_ready=1, counters 0; the following word is emitted cleanly from byte 0.
